// File: rtl/uart_pkg.sv
// Shared definitions for the Avalon-MM UART slave: register map, status bit
// positions and the transmitter/receiver state encodings.
package uart_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] RX_BASE     = 5'h00;
    localparam logic [ADDR_W-1:0] TX_BASE     = 5'h04;
    localparam logic [ADDR_W-1:0] STATUS_BASE = 5'h08;

    localparam int unsigned TX_OK_BIT = 6;
    localparam int unsigned RX_OK_BIT = 7;
    localparam int unsigned OVR_BIT   = 1;
    localparam int unsigned FERR_BIT  = 0;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer, start-bit glitch rejection, mid-bit
// sampling. Emits a one-cycle done or frame-error pulse per frame.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       avm_clk,
    input  logic       avm_rst,
    input  logic       uart_rxd,
    output logic       rx_done,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1;
    logic             sync2;
    logic             rxd_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            rxd_prev <= 1'b1;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            sync1    <= uart_rxd;
            sync2    <= sync1;
            rxd_prev <= sync2;
            rx_done  <= 1'b0;
            rx_ferr  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rxd_prev && !sync2) begin
                        cnt   <= '0;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    // Line back high at half a bit means a glitch, not a start bit
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {sync2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (sync2) begin
                            rx_data <= shift;
                            rx_done <= 1'b1;
                            state   <= RX_IDLE;
                        end else begin
                            rx_ferr <= 1'b1;
                            state   <= RX_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_BREAK: begin
                    if (sync2) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/avalon_uart_slave.sv
// Avalon-MM slave exposing an 8N1 UART: RX_DATA, TX_DATA and STATUS registers,
// two-cycle bus handshake, transmitter with a one-byte holding register.
module avalon_uart_slave
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic              avm_clk,
    input  logic              avm_rst,
    input  logic [ADDR_W-1:0] avm_address,
    input  logic              avm_read,
    output logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_write,
    input  logic [DATA_W-1:0] avm_writedata,
    output logic              avm_waitrequest,
    input  logic              uart_rxd,
    output logic              uart_txd
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             ack;
    logic             tx_ready;
    logic [7:0]       tx_hold;
    tx_state_t        tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit_idx;
    logic [7:0]       tx_shift;
    logic             rx_ready;
    logic             rx_overrun;
    logic             rx_frame_err;
    logic [7:0]       rx_byte;
    logic             rx_done;
    logic [7:0]       rx_data;
    logic             rx_ferr;

    logic             req_c;
    logic             accept_c;
    logic             complete_c;
    logic             wr_only_c;
    logic [2:0]       sel_c;
    logic             rx_rd_done_c;
    logic             st_rd_done_c;
    logic             tx_wr_c;
    logic [DATA_W-1:0] status_c;
    logic             unused_bits;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .avm_clk (avm_clk),
        .avm_rst (avm_rst),
        .uart_rxd(uart_rxd),
        .rx_done (rx_done),
        .rx_data (rx_data),
        .rx_ferr (rx_ferr)
    );

    // First cycle of a request stalls; the second completes it
    assign req_c           = avm_read | avm_write;
    assign accept_c        = req_c & ~ack;
    assign complete_c      = req_c & ack;
    assign avm_waitrequest = accept_c;
    assign wr_only_c       = avm_write & ~avm_read;
    assign sel_c           = avm_address[4:2];
    assign rx_rd_done_c    = complete_c & avm_read & (sel_c == RX_BASE[4:2]);
    assign st_rd_done_c    = complete_c & avm_read & (sel_c == STATUS_BASE[4:2]);
    assign tx_wr_c         = complete_c & wr_only_c & (sel_c == TX_BASE[4:2]) & tx_ready;
    assign unused_bits     = ^{avm_address[1:0], avm_writedata[DATA_W-1:8]};

    always_comb begin
        status_c            = '0;
        status_c[RX_OK_BIT] = rx_ready;
        status_c[TX_OK_BIT] = tx_ready;
        status_c[OVR_BIT]   = rx_overrun;
        status_c[FERR_BIT]  = rx_frame_err;
    end

    // Read data is captured while stalled so it is stable in the completing cycle
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            ack          <= 1'b0;
            avm_readdata <= '0;
        end else begin
            ack <= accept_c;
            if (accept_c && avm_read) begin
                if (sel_c == RX_BASE[4:2]) begin
                    avm_readdata <= {24'h0, rx_byte};
                end else if (sel_c == STATUS_BASE[4:2]) begin
                    avm_readdata <= status_c;
                end else begin
                    avm_readdata <= '0;
                end
            end
        end
    end

    // Receive flags: a byte finishing alongside an RX_DATA read replaces the old one
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            rx_ready     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_byte      <= '0;
        end else begin
            if (st_rd_done_c) begin
                rx_overrun   <= 1'b0;
                rx_frame_err <= 1'b0;
            end
            if (rx_done) begin
                if (!rx_ready || rx_rd_done_c) begin
                    rx_byte  <= rx_data;
                    rx_ready <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_rd_done_c) begin
                rx_ready <= 1'b0;
            end
            if (rx_ferr) begin
                rx_frame_err <= 1'b1;
            end
        end
    end

    // Transmitter; tx_ready low means the holding register is full
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_bit_idx <= '0;
            tx_shift   <= '0;
            tx_hold    <= '0;
            tx_ready   <= 1'b1;
            uart_txd   <= 1'b1;
        end else begin
            if (tx_wr_c) begin
                tx_hold  <= avm_writedata[7:0];
                tx_ready <= 1'b0;
            end
            case (tx_state)
                TX_IDLE: begin
                    uart_txd <= 1'b1;
                    if (!tx_ready) begin
                        tx_shift <= tx_hold;
                        tx_ready <= 1'b1;
                        uart_txd <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt     <= '0;
                        uart_txd   <= tx_shift[0];
                        tx_shift   <= {1'b0, tx_shift[7:1]};
                        tx_bit_idx <= '0;
                        tx_state   <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit_idx == 3'd7) begin
                            uart_txd <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            uart_txd   <= tx_shift[0];
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                            tx_bit_idx <= tx_bit_idx + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        // A queued byte starts its frame with no idle bit in between
                        if (!tx_ready) begin
                            tx_shift <= tx_hold;
                            tx_ready <= 1'b1;
                            uart_txd <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_uart_slave.sv
// Scoreboard bench for avalon_uart_slave at four clocks per bit: bus reads and
// serial frames are queued as expectations and checked by independent monitors.
module tb_avalon_uart_slave;

    localparam int unsigned CPB = 4;

    logic        avm_clk = 1'b0;
    logic        avm_rst = 1'b1;
    logic [4:0]  avm_address = '0;
    logic        avm_read = 1'b0;
    logic [31:0] avm_readdata;
    logic        avm_write = 1'b0;
    logic [31:0] avm_writedata = '0;
    logic        avm_waitrequest;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;

    typedef struct {
        logic [7:0] b;
        bit         abort_ok;
    } tx_exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    tx_exp_t     tx_q[$];
    int          tx_start_q[$];

    avalon_uart_slave #(.CLKS_PER_BIT(CPB)) dut (
        .avm_clk        (avm_clk),
        .avm_rst        (avm_rst),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .uart_rxd       (uart_rxd),
        .uart_txd       (uart_txd)
    );

    always #5 avm_clk = ~avm_clk;
    always @(posedge avm_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge avm_clk);
        #1;
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [4:0] a, input logic [31:0] d);
        bit done;
        done = 1'b0;
        avm_read = rd;
        avm_write = wr;
        avm_address = a;
        avm_writedata = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge avm_clk);
            if (!avm_waitrequest) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL bus_timeout: addr %h still stalled", a);
        end
        @(posedge avm_clk);
        #1;
        avm_read = 1'b0;
        avm_write = 1'b0;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [31:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        bus(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic hold_rxd(input logic v);
        uart_rxd = v;
        repeat (CPB) @(posedge avm_clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        hold_rxd(1'b0);
        for (int i = 0; i < 8; i++) hold_rxd(b[i]);
        hold_rxd(stop);
        uart_rxd = 1'b1;
        idle(6);
    endtask

    // Bus monitor: stall length and read data on every completing cycle
    initial begin
        int wcnt;
        logic [31:0] e;
        string n;
        wcnt = 0;
        forever begin
            @(negedge avm_clk);
            if (!avm_rst && (avm_read || avm_write)) begin
                if (avm_waitrequest) begin
                    wcnt++;
                end else begin
                    check("wait_cycles", 32'(wcnt), 32'd1);
                    if (avm_read) begin
                        if (rd_exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL rd_unexpected: got %h want no read", avm_readdata);
                        end else begin
                            e = rd_exp_q.pop_front();
                            n = rd_name_q.pop_front();
                            check(n, avm_readdata, e);
                        end
                    end
                    wcnt = 0;
                end
            end
        end
    end

    // Serial monitor: every cycle of a 10-bit frame must match the expected level
    initial begin
        tx_exp_t e;
        bit have, ok, aborted;
        logic eb;
        int bad_at;
        forever begin
            @(negedge avm_clk);
            if (!avm_rst && uart_txd === 1'b0) begin
                tx_start_q.push_back(cyc);
                have = 1'b0;
                e.b = 8'h00;
                e.abort_ok = 1'b0;
                if (tx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: frame at cycle %0d want none", cyc);
                end else begin
                    e = tx_q.pop_front();
                    have = 1'b1;
                end
                ok = 1'b1;
                aborted = 1'b0;
                bad_at = -1;
                for (int i = 0; i < 40; i++) begin
                    if (i > 0) @(negedge avm_clk);
                    if (avm_rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i < 4) eb = 1'b0;
                    else if (i < 36) eb = e.b[3'((i - 4) / 4)];
                    else eb = 1'b1;
                    if (uart_txd !== eb && ok) begin
                        ok = 1'b0;
                        bad_at = i;
                    end
                end
                if (have) begin
                    if (aborted) begin
                        if (!e.abort_ok) begin
                            total++;
                            bad++;
                            $display("FAIL tx_abort: frame %h cut by reset want complete", e.b);
                        end
                    end else begin
                        total++;
                        if (!ok) begin
                            bad++;
                            $display("FAIL tx_frame: byte %h wrong level at frame cycle %0d want exact 8N1", e.b, bad_at);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tx_exp_t t;
        repeat (3) @(posedge avm_clk);
        #1;
        avm_rst = 1'b0;
        @(negedge avm_clk);
        check("rst_txd", 32'(uart_txd), 32'd1);
        check("rst_waitreq", 32'(avm_waitrequest), 32'd0);
        check("rst_readdata", avm_readdata, 32'h0);
        @(posedge avm_clk);
        #1;

        rd_chk(5'h08, 32'h40, "st_idle");

        t.b = 8'hA5; t.abort_ok = 1'b0; tx_q.push_back(t);
        bus(1'b0, 1'b1, 5'h04, 32'hFFFF_FFA5);
        rd_chk(5'h08, 32'h00, "st_tx_busy");
        rd_chk(5'h08, 32'h40, "st_tx_free");
        idle(50);

        send_rx(8'h3C, 1'b1);
        rd_chk(5'h08, 32'hC0, "st_rx_ready");
        rd_chk(5'h00, 32'h3C, "rx_3c");
        rd_chk(5'h08, 32'h40, "st_rx_clear");

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_chk(5'h08, 32'hC2, "st_overrun");
        rd_chk(5'h00, 32'h11, "rx_keep_first");
        rd_chk(5'h08, 32'h40, "st_ovr_clear");

        send_rx(8'h55, 1'b0);
        idle(4);
        rd_chk(5'h08, 32'h41, "st_frame_err");
        rd_chk(5'h08, 32'h40, "st_ferr_clear");

        uart_rxd = 1'b0;
        idle(1);
        uart_rxd = 1'b1;
        idle(20);
        rd_chk(5'h08, 32'h40, "st_glitch");

        rd_chk(5'h0C, 32'h0, "unmapped_rd");
        bus(1'b0, 1'b1, 5'h10, 32'h77);
        rd_exp_q.push_back(32'h0);
        rd_name_q.push_back("rd_wr_same");
        bus(1'b1, 1'b1, 5'h04, 32'h66);
        rd_chk(5'h08, 32'h40, "st_no_tx");
        idle(50);

        tx_start_q.delete();
        t.b = 8'h01; t.abort_ok = 1'b0; tx_q.push_back(t);
        t.b = 8'h02; t.abort_ok = 1'b1; tx_q.push_back(t);
        bus(1'b0, 1'b1, 5'h04, 32'h01);
        bus(1'b0, 1'b1, 5'h04, 32'h02);
        rd_chk(5'h08, 32'h00, "st_queued");
        idle(60);
        avm_rst = 1'b1;
        idle(1);
        avm_rst = 1'b0;
        @(negedge avm_clk);
        check("txd_after_rst", 32'(uart_txd), 32'd1);
        check("tx_contig", (tx_start_q.size() == 2) ? 32'(tx_start_q[1] - tx_start_q[0]) : 32'hFFFF_FFFF, 32'd40);
        @(posedge avm_clk);
        #1;
        rd_chk(5'h08, 32'h40, "st_after_rst");
        idle(60);
        check("tx_drained", 32'(tx_q.size()), 32'd0);
        check("rd_drained", 32'(rd_exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
